ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs) or 0xFF (reset), using the standard request-to-send sequence, then reports the device acknowledge. It runs beside the PS/2 receive path on the same CLK and PS2_CLK/PS2_DATA pins. It drives the pins only through open-drain pull-low enables.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_line_sync.sv | 28 ++
 rtl/ps2_host_tx.sv | 188 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 definitions (tx state enum, default timings, command bytes).
package ps2_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_INHIBIT,
        TX_REQ,
        TX_DATA,
        TX_PARITY,
        TX_STOP,
        TX_ACK,
        TX_WAIT_IDLE
    } tx_state_t;

    localparam int PS2_INHIBIT_CYCLES = 5000;
    localparam int PS2_TIMEOUT_CYCLES = 750000;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_ACK         = 8'hFA;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-flop synchronizer plus falling-edge pulse for one PS/2 line.
module ps2_line_sync (
    input  logic CLK,
    input  logic reset,
    input  logic i_line,
    output logic o_level,
    output logic o_fall
);

    logic r_s1, r_s2, r_prev;

    // Reset to the idle-high bus level so leaving reset never fakes an edge.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_s1   <= 1'b1;
            r_s2   <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_s1   <= i_line;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_fall  = r_prev & ~r_s2;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter driving open-drain pull-low enables.
// Define PS2_TX_TIMEOUT_EN to abort frames the device never finishes clocking.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic       ps2_clk_low,
    output logic       ps2_data_low,
    output logic       tx_done,
    output logic       ack_err,
    output logic       timeout_err
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);

    tx_state_t     r_state, w_state_n;
    logic [IW-1:0] r_cnt, w_cnt_n;
    logic [2:0]    r_bit, w_bit_n;
    logic [7:0]    r_data, w_data_n;
    logic          r_par, w_par_n;
    logic          r_tx_ready, r_clk_low, r_data_low, r_done, r_ack_err;
    logic          w_data_low_n, w_done_n, w_ack_err_n;
    logic          w_clk_lvl, w_clk_fall, w_data_lvl, w_unused_data_fall;
    logic          w_accept, w_tmo_hit;

    ps2_line_sync u_clk_sync (
        .CLK     (CLK),
        .reset   (reset),
        .i_line  (PS2_CLK),
        .o_level (w_clk_lvl),
        .o_fall  (w_clk_fall)
    );

    ps2_line_sync u_data_sync (
        .CLK     (CLK),
        .reset   (reset),
        .i_line  (PS2_DATA),
        .o_level (w_data_lvl),
        .o_fall  (w_unused_data_fall)
    );

    assign w_accept = tx_valid & r_tx_ready;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_tmo_cnt;
    logic          r_tmo_err;
    logic          w_tmo_active;

    // Watchdog spans from REQ entry until WAIT_IDLE is left.
    assign w_tmo_active = r_state inside {TX_REQ, TX_DATA, TX_PARITY, TX_STOP, TX_ACK, TX_WAIT_IDLE};
    assign w_tmo_hit    = w_tmo_active && (r_tmo_cnt == TMO_LAST);

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_tmo_cnt <= '0;
            r_tmo_err <= 1'b0;
        end else begin
            r_tmo_cnt <= (w_tmo_active && !w_tmo_hit) ? r_tmo_cnt + 1'b1 : '0;
            r_tmo_err <= w_tmo_hit;
        end
    end

    assign timeout_err = r_tmo_err;
`else
    logic w_unused_tmo;

    assign w_tmo_hit    = 1'b0;
    assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
    assign timeout_err  = 1'b0;
`endif

    always_comb begin
        w_state_n    = r_state;
        w_cnt_n      = r_cnt;
        w_bit_n      = r_bit;
        w_data_n     = r_data;
        w_par_n      = r_par;
        w_data_low_n = r_data_low;
        w_done_n     = 1'b0;
        w_ack_err_n  = r_ack_err;
        case (r_state)
            TX_IDLE: begin
                if (w_accept) begin
                    w_state_n    = TX_INHIBIT;
                    w_cnt_n      = '0;
                    w_data_n     = tx_data;
                    w_par_n      = odd_parity(tx_data);
                    w_data_low_n = (INH_LAST == '0);
                end
            end
            TX_INHIBIT: begin
                w_cnt_n = r_cnt + 1'b1;
                if (r_cnt == INH_LAST) w_state_n = TX_REQ;
                else if (w_cnt_n == INH_LAST) w_data_low_n = 1'b1;
            end
            TX_REQ: begin
                if (w_clk_fall) begin
                    w_state_n    = TX_DATA;
                    w_data_low_n = ~r_data[0];
                    w_bit_n      = 3'd1;
                end
            end
            TX_DATA: begin
                if (w_clk_fall) begin
                    w_data_low_n = ~r_data[r_bit];
                    w_bit_n      = r_bit + 1'b1;
                    if (r_bit == 3'd7) w_state_n = TX_PARITY;
                end
            end
            TX_PARITY: begin
                if (w_clk_fall) begin
                    w_data_low_n = ~r_par;
                    w_state_n    = TX_STOP;
                end
            end
            TX_STOP: begin
                if (w_clk_fall) begin
                    w_data_low_n = 1'b0;
                    w_state_n    = TX_ACK;
                end
            end
            TX_ACK: begin
                if (w_clk_fall) begin
                    w_ack_err_n = w_data_lvl;
                    w_state_n   = TX_WAIT_IDLE;
                end
            end
            TX_WAIT_IDLE: begin
                if (w_clk_lvl && w_data_lvl) begin
                    w_done_n  = 1'b1;
                    w_state_n = TX_IDLE;
                end
            end
            default: w_state_n = TX_IDLE;
        endcase
        if (w_tmo_hit) begin
            w_state_n = TX_IDLE;
            w_done_n  = 1'b0;
        end
    end

    // Pin enables and ready are decoded from the next state so every output is a flop.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state    <= TX_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_data     <= '0;
            r_par      <= 1'b0;
            r_tx_ready <= 1'b1;
            r_clk_low  <= 1'b0;
            r_data_low <= 1'b0;
            r_done     <= 1'b0;
            r_ack_err  <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_bit      <= w_bit_n;
            r_data     <= w_data_n;
            r_par      <= w_par_n;
            r_tx_ready <= (w_state_n == TX_IDLE);
            r_clk_low  <= (w_state_n == TX_INHIBIT);
            r_data_low <= (w_state_n == TX_IDLE) ? 1'b0 : w_data_low_n;
            r_done     <= w_done_n;
            r_ack_err  <= w_ack_err_n;
        end
    end

    assign tx_ready     = r_tx_ready;
    assign ps2_clk_low  = r_clk_low;
    assign ps2_data_low = r_data_low;
    assign tx_done      = r_done;
    assign ack_err      = r_ack_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: drives ps2_host_tx against a wired-AND PS/2 device model clocking at 40 cycles.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_low, ps2_data_low, tx_done, ack_err, timeout_err;
    logic       PS2_CLK, PS2_DATA;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    int         vectors = 0;
    int         miscompares = 0;
    int         done_cnt = 0;

    assign PS2_CLK  = dev_clk & ~ps2_clk_low;
    assign PS2_DATA = dev_data & ~ps2_data_low;

    ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(2000)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .PS2_CLK      (PS2_CLK),
        .PS2_DATA     (PS2_DATA),
        .ps2_clk_low  (ps2_clk_low),
        .ps2_data_low (ps2_data_low),
        .tx_done      (tx_done),
        .ack_err      (ack_err),
        .timeout_err  (timeout_err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (tx_done) done_cnt <= done_cnt + 1;

    typedef struct {
        logic [7:0] d;
        bit         ack;
        logic       par;
        logic       err;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Frame as the device sees it on its rising edges: data LSB first, odd parity, stop.
    function automatic logic [9:0] model_frame(input logic [7:0] d);
        logic par;
        par = (($countones(d) % 2) == 0);
        return {1'b1, par, d};
    endfunction

    task automatic start(input logic [7:0] d, input bit keep, input logic [7:0] nd);
        int n = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        check("accept_clk_low", ps2_clk_low, 1);
        check("accept_ready", tx_ready, 0);
        if (keep) tx_data = nd;
        else tx_valid = 1'b0;
        while (ps2_clk_low && n < 1000) begin
            n++;
            tick();
        end
        check("inhibit_len", n, 20);
        check("start_bit", ps2_data_low, 1);
    endtask

    task automatic play(input bit ack, input int pulses, output logic [9:0] frame);
        frame = '0;
        repeat (5) tick();
        for (int k = 0; k < pulses; k++) begin
            if (k == 10) begin
                dev_data = !ack;
                repeat (10) tick();
            end
            dev_clk = 1'b0;
            repeat (20) tick();
            if (k < 10) frame[k] = PS2_DATA;
            dev_clk  = 1'b1;
            dev_data = 1'b1;
            if (k < pulses - 1) repeat (20) tick();
        end
    endtask

    task automatic finish_frame(input logic exp_err);
        int n = 0;
        while (!tx_done && n < 300) begin
            n++;
            tick();
        end
        check("done_seen", tx_done, 1);
        check("ack_err", ack_err, exp_err);
        check("ready_with_done", tx_ready, 1);
    endtask

    initial begin
        vec_t       tbl[4];
        logic [9:0] fr;
        logic [7:0] d;
        bit         a;
        int         d0, n;
        tbl[0] = '{d: PS2_CMD_SET_LED, ack: 1'b1, par: 1'b1, err: 1'b0};
        tbl[1] = '{d: 8'h01,           ack: 1'b1, par: 1'b0, err: 1'b0};
        tbl[2] = '{d: PS2_CMD_RESET,   ack: 1'b1, par: 1'b1, err: 1'b0};
        tbl[3] = '{d: PS2_CMD_SET_LED, ack: 1'b0, par: 1'b1, err: 1'b1};

        repeat (3) tick();
        check("rst_ready", tx_ready, 1);
        check("rst_clk_low", ps2_clk_low, 0);
        check("rst_data_low", ps2_data_low, 0);
        check("rst_done", tx_done, 0);
        check("rst_ack_err", ack_err, 0);
        check("rst_timeout", timeout_err, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            d0 = done_cnt;
            start(tbl[i].d, 1'b0, 8'h00);
            play(tbl[i].ack, 11, fr);
            check("frame", fr, model_frame(tbl[i].d));
            check("parity_bit", fr[8], tbl[i].par);
            finish_frame(tbl[i].err);
            tick();
            check("done_one_cycle", tx_done, 0);
            check("done_count", done_cnt - d0, 1);
        end

        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom_range(0, 255));
            a = 1'($urandom_range(0, 1));
            start(d, 1'b0, 8'h00);
            play(a, 11, fr);
            check("rand_frame", fr, model_frame(d));
            finish_frame(!a);
            tick();
        end

        d0 = done_cnt;
        start(PS2_CMD_SET_LED, 1'b1, 8'h55);
        play(1'b1, 11, fr);
        check("hold_frame_ed", fr, model_frame(PS2_CMD_SET_LED));
        finish_frame(1'b0);
        check("hold_single_done", done_cnt - d0, 0);
        start(8'h55, 1'b0, 8'h00);
        play(1'b1, 11, fr);
        check("hold_frame_55", fr, model_frame(8'h55));
        finish_frame(1'b0);
        tick();
        check("hold_done_total", done_cnt - d0, 2);

        d0 = done_cnt;
        start(PS2_CMD_SET_LED, 1'b0, 8'h00);
        play(1'b1, 4, fr);
        reset = 1'b1;
        tick();
        check("mid_rst_clk_low", ps2_clk_low, 0);
        check("mid_rst_data_low", ps2_data_low, 0);
        check("mid_rst_ready", tx_ready, 1);
        check("mid_rst_done", tx_done, 0);
        reset = 1'b0;
        repeat (200) tick();
        check("mid_rst_no_done", done_cnt - d0, 0);
        check("mid_rst_idle", tx_ready, 1);

        d0 = done_cnt;
        start(PS2_CMD_RESET, 1'b0, 8'h00);
`ifdef PS2_TX_TIMEOUT_EN
        n = 0;
        while (!timeout_err && n < 5000) begin
            n++;
            tick();
        end
        check("timeout_latency", n, 2000);
        check("timeout_clk_low", ps2_clk_low, 0);
        check("timeout_data_low", ps2_data_low, 0);
        check("timeout_ready", tx_ready, 1);
        tick();
        check("timeout_pulse", timeout_err, 0);
        check("timeout_no_done", done_cnt - d0, 0);
`else
        n = 0;
        repeat (3000) begin
            tick();
            if (timeout_err) n++;
        end
        check("no_timeout_err", n, 0);
        check("stall_still_req", ps2_data_low, 1);
        check("stall_busy", tx_ready, 0);
        check("stall_no_done", done_cnt - d0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("stall_recover", tx_ready, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
